// File: rtl/dw_conv_post_process.sv
// dw_conv_post_process
// Output side of the depthwise-conv datapath. It consumes one accumulator beat
// per raster input position and drops the beats whose 3x3 window was not fully
// populated. It can also decimate for stride 2. Each channel is requantized
// (round, arithmetic shift, optional ReLU, saturate), and the result is a dense
// raster stream for the next layer.
//
// Handshake: valid_in / valid_out are plain valid strobes with no ready.
// Every valid_in beat is consumed in the cycle it is presented. Every
// valid_out beat must be taken by the consumer in the cycle it is presented.
// A kept beat reaches valid_out exactly two cycles after its valid_in.

module dw_conv_post_process #(
   parameter int DATA_WIDTH      = 8,
   parameter int OUT_CHANNEL_NUM = 18,
   parameter int ACC_WIDTH       = 20,
   parameter int MAX_WIDTH       = 320,
   parameter int MAX_HEIGHT      = 320,
   parameter int W_BITS          = $clog2(MAX_WIDTH + 1),
   parameter int H_BITS          = $clog2(MAX_HEIGHT + 1),
   parameter int SHIFT_BITS      = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [OUT_CHANNEL_NUM*ACC_WIDTH-1:0]  acc_in,
   input  logic                                  valid_in,
   output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out,
   output logic                                  valid_out,
   output logic                                  frame_done,
   input  logic                                  cfg_load,
   input  logic [W_BITS-1:0]                     img_width,
   input  logic [H_BITS-1:0]                     img_height,
   input  logic [SHIFT_BITS-1:0]                 quant_shift,
   input  logic                                  relu_en,
   input  logic                                  stride2,
   output logic                                  cfg_err
);

   // Stage-1 arithmetic is one bit wider than the accumulator, so the rounding
   // add cannot overflow.
   localparam int ACC1 = ACC_WIDTH + 1;

   // Saturation bounds for a signed DATA_WIDTH result, expressed at stage-1 width.
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = $signed(ACC1'((2 ** (DATA_WIDTH - 1)) - 1));
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   // Configuration latched on a legal cfg_load.
   logic [W_BITS-1:0]     cfg_wm1;      // W-1: last column of a row
   logic [H_BITS-1:0]     cfg_hm1;      // H-1: last row of the frame
   logic [W_BITS-1:0]     last_col;     // column of the final kept position
   logic [H_BITS-1:0]     last_row;     // row of the final kept position
   logic [SHIFT_BITS-1:0] cfg_shift;
   logic                  cfg_relu;
   logic                  cfg_stride2;

   // Raster position of the next incoming beat.
   logic [W_BITS-1:0] col;
   logic [H_BITS-1:0] row;

   logic cfg_legal;
   logic beat;
   logic at_end;
   logic keep;
   logic last;

   // Stage-1 pipeline registers.
   logic signed [ACC_WIDTH:0] s1_val [OUT_CHANNEL_NUM];
   logic                      s1_keep;
   logic                      s1_last;

   // Combinational stage-1 and stage-2 datapath.
   logic signed [ACC_WIDTH:0]               acc_ext   [OUT_CHANNEL_NUM];
   logic signed [ACC_WIDTH:0]               acc_sum   [OUT_CHANNEL_NUM];
   logic signed [ACC_WIDTH:0]               acc_shift [OUT_CHANNEL_NUM];
   logic signed [ACC_WIDTH:0]               round_add;
   logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0]   data_nxt;

   // A configuration is accepted only if a full 3x3 window fits and the image fits the line storage.
   assign cfg_legal = (img_width  >= W_BITS'(3)) && (img_height >= H_BITS'(3)) &&
                      (img_width  <= W_BITS'(MAX_WIDTH)) &&
                      (img_height <= H_BITS'(MAX_HEIGHT));

   // A beat counts only while running. A simultaneous cfg_load wins and the beat is dropped.
   assign beat   = valid_in && (state == RUN) && !cfg_load;
   assign at_end = (row == cfg_hm1) && (col == cfg_wm1);

   // Window-complete test, plus even-offset decimation for stride 2.
   // (row-2) is even exactly when row is even.
   assign keep = (row >= H_BITS'(2)) && (col >= W_BITS'(2)) &&
                 (!cfg_stride2 || (!row[0] && !col[0]));
   assign last = keep && (row == last_row) && (col == last_col);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: a load (re)starts or parks the block, and the final raster beat ends the frame.
   always_comb begin
      state_nxt = state;
      if (cfg_load) begin
         state_nxt = cfg_legal ? RUN : IDLE;
      end else if ((state == RUN) && valid_in && at_end) begin
         state_nxt = IDLE;
      end
   end

   // Configuration capture, and the sticky error flag for rejected loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_wm1     <= '0;
         cfg_hm1     <= '0;
         last_col    <= '0;
         last_row    <= '0;
         cfg_shift   <= '0;
         cfg_relu    <= 1'b0;
         cfg_stride2 <= 1'b0;
         cfg_err     <= 1'b0;
      end else if (cfg_load) begin
         cfg_err <= !cfg_legal;
         if (cfg_legal) begin
            cfg_wm1     <= img_width  - W_BITS'(1);
            cfg_hm1     <= img_height - H_BITS'(1);
            // With stride 2 an even dimension leaves its last line at an odd
            // offset from 2. The final kept line is then one earlier.
            last_col    <= (stride2 && !img_width[0])  ? img_width  - W_BITS'(2)
                                                       : img_width  - W_BITS'(1);
            last_row    <= (stride2 && !img_height[0]) ? img_height - H_BITS'(2)
                                                       : img_height - H_BITS'(1);
            cfg_shift   <= quant_shift;
            cfg_relu    <= relu_en;
            cfg_stride2 <= stride2;
         end
      end
   end

   // Raster position counters. A load restarts them at (0,0), and the final beat returns them to (0,0).
   always_ff @(posedge clk) begin
      if (rst || cfg_load) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (col == cfg_wm1) begin
            col <= '0;
            row <= at_end ? '0 : row + H_BITS'(1);
         end else begin
            col <= col + W_BITS'(1);
         end
      end
   end

   // Stage-1 datapath: sign-extend, add the half-LSB rounding term, then shift arithmetically.
   always_comb begin
      round_add = '0;
      if (cfg_shift != '0) begin
         round_add = ACC1'(1) << (cfg_shift - SHIFT_BITS'(1));
      end
      for (int k = 0; k < OUT_CHANNEL_NUM; k++) begin
         acc_ext[k]   = $signed({acc_in[k*ACC_WIDTH + ACC_WIDTH - 1], acc_in[k*ACC_WIDTH +: ACC_WIDTH]});
         acc_sum[k]   = acc_ext[k] + round_add;
         acc_shift[k] = acc_sum[k] >>> cfg_shift;
      end
   end

   // Stage-1 registers. A load flushes the valid flags, so beats taken before the load never surface.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_keep <= 1'b0;
         s1_last <= 1'b0;
         for (int k = 0; k < OUT_CHANNEL_NUM; k++) begin
            s1_val[k] <= '0;
         end
      end else begin
         s1_keep <= beat && keep;
         s1_last <= beat && last;
         if (beat) begin
            for (int k = 0; k < OUT_CHANNEL_NUM; k++) begin
               s1_val[k] <= acc_shift[k];
            end
         end
      end
   end

   // Stage-2 datapath: optional ReLU, then saturate to the signed output range.
   always_comb begin
      data_nxt = '0;
      for (int k = 0; k < OUT_CHANNEL_NUM; k++) begin
         if (cfg_relu && s1_val[k][ACC_WIDTH]) begin
            data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else if (s1_val[k] > SAT_MAX) begin
            data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
         end else if (s1_val[k] < SAT_MIN) begin
            data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
         end else begin
            data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = s1_val[k][DATA_WIDTH-1:0];
         end
      end
   end

   // Stage-2 output registers. data_out holds between kept beats, and a load flushes the valid flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else if (cfg_load) begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= s1_keep;
         frame_done <= s1_last;
         if (s1_keep) begin
            data_out <= data_nxt;
         end
      end
   end

endmodule

// File: doc/dw_conv_post_process.md
Name: dw_conv_post_process

Overview:
- Output-side counterpart of the depthwise-conv window preprocessor. It takes the per-pixel accumulator stream produced by the depthwise MAC array, one beat per raster input position.
- Drops beats whose 3x3 window was not fully populated, i.e. the first two rows and the first two columns of each row. Optionally decimates for stride 2.
- Requantizes each channel's accumulator to DATA_WIDTH with round, shift, optional ReLU and saturation.
- Emits a dense raster feature-map stream for the next layer's preprocessor.

Parameters:
- DATA_WIDTH, 8, output element width (signed).
- OUT_CHANNEL_NUM, 18, channels per beat.
- ACC_WIDTH, 20, signed accumulator width per channel.
- MAX_WIDTH, 320, maximum input image width.
- MAX_HEIGHT, 320, maximum input image height.
- W_BITS, $clog2(MAX_WIDTH+1), width/column counter width.
- H_BITS, $clog2(MAX_HEIGHT+1), height/row counter width.
- SHIFT_BITS, 5, quant_shift width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- acc_in  in  OUT_CHANNEL_NUM*ACC_WIDTH  accumulators; channel k at bits [k*ACC_WIDTH +: ACC_WIDTH].
- valid_in  in  1  acc_in beat valid; one beat per input raster position.
- data_out  out  OUT_CHANNEL_NUM*DATA_WIDTH  requantized pixel; same channel packing.
- valid_out  out  1  data_out valid.
- frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame.
- cfg_load  in  1  latch configuration and restart counters.
- img_width  in  W_BITS  input image width W; sampled on cfg_load.
- img_height  in  H_BITS  input image height H; sampled on cfg_load.
- quant_shift  in  SHIFT_BITS  right-shift amount; sampled on cfg_load.
- relu_en  in  1  clamp negatives to 0; sampled on cfg_load.
- stride2  in  1  keep only even window positions; sampled on cfg_load.
- cfg_err  out  1  sticky: last cfg_load had W<3, H<3, W>MAX_WIDTH or H>MAX_HEIGHT.

Behaviour:
- Reset:
  - state=IDLE.
  - data_out=0, valid_out=0, frame_done=0, cfg_err=0.
  - All counters and pipeline valid flags are 0.
- States:
  - IDLE: valid_in is ignored.
  - RUN: counting.
  - IDLE->RUN on cfg_load with legal config; cfg_err cleared.
  - Illegal config: stay or go IDLE, cfg_err=1.
  - RUN->IDLE on the valid_in beat with row=H-1, col=W-1.
  - cfg_load in RUN:
    - Aborts the frame; counters zeroed.
    - Pipeline valid flags flushed, so no valid_out from pre-load beats.
    - The legal-config check is then applied as above.
- Counters:
  - col/row advance only on valid_in in RUN: col++, wrapping at W-1 to 0 with row++.
  - cfg_load has priority over a simultaneous valid_in; that beat is dropped.
- Keep rule:
  - stride1: keep = row>=2 && col>=2.
  - stride2: additionally (row-2) and (col-2) even.
  - Expected output beats:
    - stride1: (W-2)*(H-2).
    - stride2: ceil((W-2)/2)*ceil((H-2)/2).
- Pipeline: latency exactly 2 cycles from valid_in to valid_out; no backpressure.
  - Stage 1, per channel:
    - s = acc + (quant_shift>0 ? 1<<(quant_shift-1) : 0), computed at ACC_WIDTH+1 bits.
    - Arithmetic right shift by quant_shift.
    - Register keep and last, where last = keep and (row,col)=(H-1,W-1).
  - Stage 2:
    - If relu_en and value<0 -> 0.
    - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - valid_out=keep_d, frame_done=last_d.
  - data_out holds its last value when valid_out=0.
- frame_done:
  - Asserted only together with valid_out.
  - With stride2 and an odd-excluded final position, frame_done rides the last kept beat instead.
  - Implemented by computing last as "final kept position" from W, H and stride.
- Mid-operation rst: same as reset; in-flight beats are lost.

Test Plan:
- Reset, cfg W=5 H=4 shift=0 relu=0 stride1; 20 beats with acc ch0 = raster index 0..19 -> exactly 6 valid_out, ch0 = 12,13,14,17,18,19, each 2 cycles after its input; frame_done with value 19.
- Quantization: shift=4, acc=-24 -> -1 (since -24+8=-16, >>4 = -1); acc=24 -> 2; acc=40000 -> 127; acc=-40000 -> -128; relu_en=1 with -24 -> 0.
- stride2 with W=7 H=7: 49 beats -> 9 outputs at (row,col) in {2,4,6}x{2,4,6}; frame_done on (6,6).
- Gapped valid_in (random 50% idle) on the W=5 H=4 frame -> identical output sequence; valid_out never asserted without a matching input 2 cycles earlier.
- cfg_load asserted mid-frame with a beat in flight -> no valid_out for pre-load beats; new frame counts from (0,0); a simultaneous valid_in is dropped.
- cfg_load with W=2 -> cfg_err=1 and all subsequent valid_in ignored; legal cfg_load -> cfg_err=0, operation resumes.
